// File: rtl/fft_bfly_stage_pkg.sv
// Shared constants and helpers for the streaming FFT butterfly stage:
// twiddle quantisation (elaboration time) and round/saturate (datapath).
package fft_pkg;
  localparam int N_POINTS = 512;
  localparam int TW_WIDTH = 9;
  localparam int TW_FRAC  = 7;
  localparam int LANES    = 16;
  localparam int CPLX_W   = 10;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  // Q2.30 fixed point used only while building the twiddle tables
  localparam longint FX_ONE = 64'sd1 <<< 30;
  localparam longint PI_FX  = 64'sd3373259426;

  function automatic longint taylor_fx(longint x, bit odd);
    longint term, acc;
    int     d;
    term = odd ? x : FX_ONE;
    acc  = term;
    for (int k = 1; k < 10; k++) begin
      d    = odd ? (2*k)*(2*k+1) : (2*k-1)*(2*k);
      term = (((term * x) >>> 30) * x) >>> 30;
      term = -term / longint'(d);
      acc  = acc + term;
    end
    return acc;
  endfunction

  // Component of exp(-j*2*pi*m/n_pts), m in [0, n_pts/2), round-to-nearest
  function automatic int twiddle_q(int m, int n_pts, int frac, bit want_im);
    int     mm, q;
    bit     mirror;
    longint x, v, mag;
    mm     = m;
    mirror = 1'b0;
    if (4*mm > n_pts) begin
      mm     = n_pts/2 - mm;
      mirror = 1'b1;
    end
    x = (2 * PI_FX * longint'(mm)) / longint'(n_pts);
    if (want_im) v = -taylor_fx(x, 1'b1);
    else         v = mirror ? -taylor_fx(x, 1'b0) : taylor_fx(x, 1'b0);
    mag = (v < 0) ? -v : v;
    mag = ((mag <<< frac) + (FX_ONE >>> 1)) >>> 30;
    q   = int'(mag);
    return (v < 0) ? -q : q;
  endfunction

  function automatic longint rnd_sat(longint acc, int frac, int ow);
    longint r, hi, lo;
    r  = (acc + (longint'(1) <<< (frac-1))) >>> frac;
    hi = (longint'(1) <<< (ow-1)) - 1;
    lo = -hi - 1;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction
endpackage

// File: rtl/fft_bfly_stage_if.sv
// Operand/result bundle between the delay stage, butterfly and downstream.
interface fft_bfly_stage_if import fft_pkg::*; #(
  parameter int DATA_WIDTH = 9,
  parameter int OUT_WIDTH  = DATA_WIDTH + 1
);
  logic [LANES-1:0][DATA_WIDTH-1:0] din_a_re, din_a_im, din_b_re, din_b_im;
  logic                             bfly_valid;
  logic [LANES-1:0][OUT_WIDTH-1:0]  sum_re, sum_im, dif_re, dif_im;
  logic                             dout_valid;
  logic                             blk_last;

  modport master (
    output din_a_re, din_a_im, din_b_re, din_b_im, bfly_valid,
    input  sum_re, sum_im, dif_re, dif_im, dout_valid, blk_last
  );
  modport slave (
    input  din_a_re, din_a_im, din_b_re, din_b_im, bfly_valid,
    output sum_re, sum_im, dif_re, dif_im, dout_valid, blk_last
  );
endinterface

// File: rtl/fft_twiddle_rom.sv
// Per-block twiddle ROM: 16 lanes of W = exp(-j2*pi*m/N), registered read.
module fft_twiddle_rom import fft_pkg::*; #(
  parameter int N_POINTS  = fft_pkg::N_POINTS,
  parameter int MEM_DEPTH = 128,
  parameter int TW_WIDTH  = fft_pkg::TW_WIDTH,
  localparam int NBLK     = MEM_DEPTH / LANES,
  localparam int BW       = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [BW-1:0]                   blk_idx,
  output logic [LANES-1:0][TW_WIDTH-1:0]  tw_re,
  output logic [LANES-1:0][TW_WIDTH-1:0]  tw_im
);
  typedef logic [NBLK-1:0][LANES-1:0][TW_WIDTH-1:0] tbl_t;

  function automatic tbl_t build(bit want_im);
    tbl_t t;
    int   q;
    t = '0;
    for (int b = 0; b < NBLK; b++) begin
      for (int l = 0; l < LANES; l++) begin
        q       = twiddle_q((b*LANES + l) * (N_POINTS/(2*MEM_DEPTH)), N_POINTS, TW_FRAC, want_im);
        t[b][l] = q[TW_WIDTH-1:0];
      end
    end
    return t;
  endfunction

  localparam tbl_t TW_RE = build(1'b0);
  localparam tbl_t TW_IM = build(1'b1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tw_re <= '0;
      tw_im <= '0;
    end else begin
      tw_re <= TW_RE[blk_idx];
      tw_im <= TW_IM[blk_idx];
    end
  end
endmodule

// File: rtl/fft_bfly_stage.sv
// Radix-2 DIF butterfly, 16 lanes: sum = a+b, dif = (a-b)*W, 3-stage pipeline.
module fft_bfly_stage import fft_pkg::*; #(
  parameter int DATA_WIDTH = 9,
  parameter int MEM_DEPTH  = 128,
  parameter int N_POINTS   = fft_pkg::N_POINTS,
  parameter int TW_WIDTH   = fft_pkg::TW_WIDTH,
  parameter int OUT_WIDTH  = DATA_WIDTH + 1
) (
  input logic            clk,
  input logic            rstn,
  fft_bfly_stage_if.slave bus
);
  localparam int NBLK = MEM_DEPTH / LANES;
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int PW   = OUT_WIDTH + TW_WIDTH;
  localparam int AW   = PW + 1;

  logic [BW-1:0]                  blk_cnt;
  logic [2:0]                     vld_pipe, last_pipe;
  logic [LANES-1:0][TW_WIDTH-1:0] tw_re, tw_im;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt   <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[1:0], bus.bfly_valid};
      last_pipe <= {last_pipe[1:0], bus.bfly_valid && (blk_cnt == BW'(NBLK-1))};
      if (bus.bfly_valid)
        blk_cnt <= (blk_cnt == BW'(NBLK-1)) ? '0 : blk_cnt + 1'b1;
    end
  end

  assign bus.dout_valid = vld_pipe[2];
  assign bus.blk_last   = last_pipe[2];

  // Read address is the pre-increment count, so the twiddle lands with S1
  fft_twiddle_rom #(
    .N_POINTS (N_POINTS),
    .MEM_DEPTH(MEM_DEPTH),
    .TW_WIDTH (TW_WIDTH)
  ) u_rom (
    .clk    (clk),
    .rstn   (rstn),
    .blk_idx(blk_cnt),
    .tw_re  (tw_re),
    .tw_im  (tw_im)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [OUT_WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic signed [OUT_WIDTH-1:0] d_re, d_im, s1_re, s1_im, s2_re, s2_im, s3_re, s3_im;
    logic signed [OUT_WIDTH-1:0] q_re, q_im;
    logic signed [TW_WIDTH-1:0]  w_re, w_im;
    logic signed [PW-1:0]        p_rr, p_ii, p_ri, p_ir;
    logic signed [AW-1:0]        acc_re, acc_im;

    assign a_re = {{(OUT_WIDTH-DATA_WIDTH){bus.din_a_re[l][DATA_WIDTH-1]}}, bus.din_a_re[l]};
    assign a_im = {{(OUT_WIDTH-DATA_WIDTH){bus.din_a_im[l][DATA_WIDTH-1]}}, bus.din_a_im[l]};
    assign b_re = {{(OUT_WIDTH-DATA_WIDTH){bus.din_b_re[l][DATA_WIDTH-1]}}, bus.din_b_re[l]};
    assign b_im = {{(OUT_WIDTH-DATA_WIDTH){bus.din_b_im[l][DATA_WIDTH-1]}}, bus.din_b_im[l]};
    assign w_re = tw_re[l];
    assign w_im = tw_im[l];

    assign acc_re = AW'(p_rr) - AW'(p_ii);
    assign acc_im = AW'(p_ri) + AW'(p_ir);

    // Each stage only loads when its slot carries data, so idle outputs hold
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        {d_re, d_im, s1_re, s1_im, s2_re, s2_im, s3_re, s3_im} <= '0;
        {p_rr, p_ii, p_ri, p_ir} <= '0;
        {q_re, q_im} <= '0;
      end else begin
        if (bus.bfly_valid) begin
          s1_re <= a_re + b_re;
          s1_im <= a_im + b_im;
          d_re  <= a_re - b_re;
          d_im  <= a_im - b_im;
        end
        if (vld_pipe[0]) begin
          p_rr  <= PW'(d_re) * PW'(w_re);
          p_ii  <= PW'(d_im) * PW'(w_im);
          p_ri  <= PW'(d_re) * PW'(w_im);
          p_ir  <= PW'(d_im) * PW'(w_re);
          s2_re <= s1_re;
          s2_im <= s1_im;
        end
        if (vld_pipe[1]) begin
          q_re  <= OUT_WIDTH'(rnd_sat(longint'(acc_re), TW_FRAC, OUT_WIDTH));
          q_im  <= OUT_WIDTH'(rnd_sat(longint'(acc_im), TW_FRAC, OUT_WIDTH));
          s3_re <= s2_re;
          s3_im <= s2_im;
        end
      end
    end

    assign bus.sum_re[l] = s3_re;
    assign bus.sum_im[l] = s3_im;
    assign bus.dif_re[l] = q_re;
    assign bus.dif_im[l] = q_im;
  end
endmodule

// File: tb/tb_fft_bfly_stage.sv
// Table + scoreboard bench for fft_bfly_stage (default 512-pt, D=128 config).
module tb_fft_bfly_stage;
  typedef logic [15:0][9:0] ovec_t;
  typedef logic [15:0][8:0] ivec_t;
  typedef struct {
    ovec_t sr, si, dr, di;
    logic  last;
    int    cyc;
  } exp_t;
  typedef struct {
    int blk, ar, ai, br, bi, sr, si, dr, di;
  } vec_t;

  logic  clk = 1'b0;
  logic  rstn = 1'b0;
  int    cyc = 0;
  int    checks = 0, errors = 0;
  int    mblk = 0;
  int    cnt_last = 0, cnt_vld = 0;
  exp_t  q[$];
  exp_t  m_e;
  ivec_t s_ar, s_ai, s_br, s_bi;
  vec_t  tv[6];
  vec_t  nov;

  fft_bfly_stage_if ifc();
  fft_bfly_stage dut (.clk(clk), .rstn(rstn), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic int sat10(int x);
    if (x > 511)  return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  function automatic exp_t model(int blk);
    exp_t e;
    real  th;
    int   a_r, a_i, b_r, b_i, d_r, d_i, wr, wi, re, im, t;
    for (int l = 0; l < 16; l++) begin
      a_r = $signed(s_ar[l]); a_i = $signed(s_ai[l]);
      b_r = $signed(s_br[l]); b_i = $signed(s_bi[l]);
      th  = 2.0 * 3.141592653589793 * real'((blk*16 + l) * 2) / 512.0;
      wr  = $rtoi($floor(128.0 * $cos(th) + 0.5));
      wi  = $rtoi($floor(-128.0 * $sin(th) + 0.5));
      d_r = a_r - b_r;
      d_i = a_i - b_i;
      re  = sat10((d_r*wr - d_i*wi + 64) >>> 7);
      im  = sat10((d_r*wi + d_i*wr + 64) >>> 7);
      t = a_r + b_r; e.sr[l] = t[9:0];
      t = a_i + b_i; e.si[l] = t[9:0];
      e.dr[l] = re[9:0];
      e.di[l] = im[9:0];
    end
    e.last = (blk == 7);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic rand_stim();
    for (int l = 0; l < 16; l++) begin
      s_ar[l] = 9'($urandom); s_ai[l] = 9'($urandom);
      s_br[l] = 9'($urandom); s_bi[l] = 9'($urandom);
    end
  endtask

  task automatic drive(input bit v, input bit ovr, input vec_t t);
    exp_t e;
    if (ovr) begin
      s_ar[0] = 9'(t.ar); s_ai[0] = 9'(t.ai);
      s_br[0] = 9'(t.br); s_bi[0] = 9'(t.bi);
    end
    ifc.din_a_re = s_ar; ifc.din_a_im = s_ai;
    ifc.din_b_re = s_br; ifc.din_b_im = s_bi;
    ifc.bfly_valid = v;
    if (v) begin
      e = model(mblk);
      if (ovr) begin
        e.sr[0] = 10'(t.sr); e.si[0] = 10'(t.si);
        e.dr[0] = 10'(t.dr); e.di[0] = 10'(t.di);
      end
      e.cyc = cyc + 3;
      q.push_back(e);
      mblk = (mblk + 1) % 8;
    end
    @(posedge clk); #1;
  endtask

  task automatic hit_reset();
    rstn = 1'b0;
    q.delete();
    mblk = 0;
    ifc.bfly_valid = 1'b0;
  endtask

  task automatic do_reset();
    hit_reset();
    s_ar = '0; s_ai = '0; s_br = '0; s_bi = '0;
    ifc.din_a_re = '0; ifc.din_a_im = '0; ifc.din_b_re = '0; ifc.din_b_im = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (ifc.dout_valid) begin
        cnt_vld++;
        if (ifc.blk_last) cnt_last++;
        if (q.size() == 0) chk("spurious_valid", ifc.dout_valid, 0);
        else begin
          m_e = q.pop_front();
          chk("out_cycle", cyc, m_e.cyc);
          chk("sum_re", ifc.sum_re, m_e.sr);
          chk("sum_im", ifc.sum_im, m_e.si);
          chk("dif_re", ifc.dif_re, m_e.dr);
          chk("dif_im", ifc.dif_im, m_e.di);
          chk("blk_last", ifc.blk_last, m_e.last);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        chk("missing_valid", ifc.dout_valid, 1);
        q.delete(0);
      end
    end
  end

  initial begin
    nov   = '{default: 0};
    //        blk   a_re  a_im   b_re  b_im   sum_re sum_im dif_re dif_im
    tv[0] = '{0,    100,  -20,   50,   10,    150,   -10,   50,    -30};
    tv[1] = '{1,    64,   0,     0,    0,     64,    0,     59,    -24};
    tv[2] = '{2,    255,  255,   -256, -256,  -1,    -1,    511,   0};
    tv[3] = '{4,    40,   0,     0,    0,     40,    0,     0,     -40};
    tv[4] = '{2,    -256, -256,  255,  255,   -1,    -1,    -512,  0};
    tv[5] = '{0,    -256, 0,     255,  0,     -1,    0,     -511,  0};

    do_reset();
    chk("rst_dout_valid", ifc.dout_valid, 0);
    chk("rst_blk_last", ifc.blk_last, 0);
    chk("rst_sum_re", ifc.sum_re, 0);
    chk("rst_dif_im", ifc.dif_im, 0);

    // Table entries; filler blocks walk the counter to each entry's block
    for (int i = 0; i < 6; i++) begin
      while (mblk != tv[i].blk) begin
        rand_stim();
        drive(1'b1, 1'b0, nov);
      end
      rand_stim();
      drive(1'b1, 1'b1, tv[i]);
    end
    repeat (5) drive(1'b0, 1'b0, nov);

    // Two full frames back to back
    do_reset();
    cnt_last = 0; cnt_vld = 0;
    for (int i = 0; i < 16; i++) begin
      rand_stim();
      drive(1'b1, 1'b0, nov);
    end
    repeat (5) drive(1'b0, 1'b0, nov);
    chk("blk_last_count", cnt_last, 2);
    chk("valid_count", cnt_vld, 16);

    // Gapped valid 1,0,0,1,1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_stim();
      drive((i == 0 || i >= 3), 1'b0, nov);
    end
    repeat (5) drive(1'b0, 1'b0, nov);

    // Reset with two blocks in flight
    rand_stim(); drive(1'b1, 1'b0, nov);
    rand_stim(); drive(1'b1, 1'b0, nov);
    hit_reset();
    #2;
    chk("midrst_valid", ifc.dout_valid, 0);
    chk("midrst_dif_re", ifc.dif_re, 0);
    chk("midrst_sum_im", ifc.sum_im, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (6) drive(1'b0, 1'b0, nov);
    rand_stim(); drive(1'b1, 1'b0, nov);
    repeat (5) drive(1'b0, 1'b0, nov);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
